pe_input_reorder: RTL

- Upstream feeder for the 4-input butterfly PE (out0..out3 / tf / bypass_n).
- Collects two consecutive N-point frames (A, then B) from a one-sample-per-cycle valid/ready stream into a register buffer.
- Drains the buffer as N/2 beats of 4 samples in first-stage DIF butterfly order, plus a twiddle index and the bypass flag.
- The PE has no backpressure, so drain runs at one beat per cycle, unstalled.

---
 rtl/rfft_pkg.sv | 24 ++
 rtl/pe_sample_buf.sv | 42 ++++
 rtl/pe_input_reorder.sv | 117 +++++++++++
 3 files changed

// File: rtl/rfft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rfft_pkg
//  Description : Shared FSM encoding and frame-size helpers for the FFT
//                stage feeders and controllers.
//  Revision    : 1.0  initial release
// ============================================================================
package rfft_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } stage_state_e;

    function automatic int frame_len(input int log2n);
        return 1 << log2n;
    endfunction

    function automatic int half_len(input int log2n);
        return (1 << log2n) >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_sample_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pe_sample_buf
//  Description : 2N x WIDTH register buffer, one write port and four
//                combinational taps at k, k+N/2, N+k and N+k+N/2.
//  Revision    : 1.0  initial release
// ============================================================================
module pe_sample_buf
    import rfft_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LOG2N = 4
) (
    input  logic             Clk,
    input  logic             we,
    input  logic [LOG2N:0]   wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [LOG2N-2:0] rd_idx,
    output logic [WIDTH-1:0] tap0,
    output logic [WIDTH-1:0] tap1,
    output logic [WIDTH-1:0] tap2,
    output logic [WIDTH-1:0] tap3
);

    localparam int c_DEPTH = 2 * frame_len(LOG2N);

    logic [WIDTH-1:0] r_mem [0:c_DEPTH-1];

    always_ff @(posedge Clk) begin
        if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Top two address bits select frame (A/B) and half; the rest is k.
    assign tap0 = r_mem[{2'b00, rd_idx}];
    assign tap1 = r_mem[{2'b01, rd_idx}];
    assign tap2 = r_mem[{2'b10, rd_idx}];
    assign tap3 = r_mem[{2'b11, rd_idx}];

endmodule
`default_nettype wire

// File: rtl/pe_input_reorder.sv
`default_nettype none
// ============================================================================
//  Module      : pe_input_reorder
//  Description : Buffers a frame pair from a serial stream and drains it as
//                N/2 four-sample beats in first-stage DIF butterfly order.
//  Revision    : 1.0  initial release
// ============================================================================
module pe_input_reorder
    import rfft_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LOG2N = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             cfg_bypass_n,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [LOG2N-2:0] tf_idx,
    output logic             bypass_n_out,
    output logic             out_valid,
    output logic             out_first
);

    localparam int               c_N       = frame_len(LOG2N);
    localparam int               c_HALF    = half_len(LOG2N);
    localparam logic [LOG2N:0]   c_WR_LAST = LOG2N'(0) | (LOG2N+1)'(2 * c_N - 1);
    localparam logic [LOG2N-2:0] c_RD_LAST = (LOG2N-1)'(c_HALF - 1);

    stage_state_e     r_state;
    logic [LOG2N:0]   r_wr_cnt;
    logic [LOG2N-2:0] r_rd_cnt;

    logic             w_accept;
    logic [WIDTH-1:0] w_tap0;
    logic [WIDTH-1:0] w_tap1;
    logic [WIDTH-1:0] w_tap2;
    logic [WIDTH-1:0] w_tap3;

    assign in_ready = (r_state == FILL);
    assign w_accept = in_valid && in_ready;

    pe_sample_buf #(
        .WIDTH (WIDTH),
        .LOG2N (LOG2N)
    ) u_buf (
        .Clk     (Clk),
        .we      (w_accept),
        .wr_addr (r_wr_cnt),
        .wr_data (in_data),
        .rd_idx  (r_rd_cnt),
        .tap0    (w_tap0),
        .tap1    (w_tap1),
        .tap2    (w_tap2),
        .tap3    (w_tap3)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= FILL;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            out0         <= '0;
            out1         <= '0;
            out2         <= '0;
            out3         <= '0;
            tf_idx       <= '0;
            bypass_n_out <= 1'b1;
            out_valid    <= 1'b0;
            out_first    <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    out_valid <= 1'b0;
                    out_first <= 1'b0;
                    if (w_accept) begin
                        // Bypass is latched once per pair, on sample A x[0].
                        if (r_wr_cnt == '0) begin
                            bypass_n_out <= cfg_bypass_n;
                        end
                        if (r_wr_cnt == c_WR_LAST) begin
                            r_wr_cnt <= '0;
                            r_state  <= DRAIN;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    out0      <= w_tap0;
                    out1      <= w_tap1;
                    out2      <= w_tap2;
                    out3      <= w_tap3;
                    tf_idx    <= r_rd_cnt;
                    out_valid <= 1'b1;
                    out_first <= (r_rd_cnt == '0);
                    if (r_rd_cnt == c_RD_LAST) begin
                        r_rd_cnt <= '0;
                        r_state  <= FILL;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
